// File: rtl/conv_out_fifo_pkg.sv
// conv_out_fifo_pkg
// Shared constants for the conv output path. It holds the conv word-width
// constants, the FIFO defaults and pointer/count width helpers, so the conv
// core and its output FIFO agree on sizes.
package conv_out_fifo_pkg;

    localparam int CONV_OUT_CHANNEL   = 2;
    localparam int CONV_DATA_WIDTH    = 8 * CONV_OUT_CHANNEL;
    localparam int FIFO_DEPTH_DEFAULT = 16;
    // Free-entry headroom that covers the words still in flight in the conv
    // pipeline after it sees a stall.
    localparam int AF_MARGIN_DEFAULT  = 4;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy has to represent 0..depth inclusive, so it needs one more bit.
    function automatic int count_width(input int depth);
        return ptr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
// Simple dual-port storage for conv_out_fifo. It has a synchronous write port
// and an asynchronous read port. The contents are not reset.
// Ports:
//   clk            write clock
//   we/waddr/wdata write port, sampled on the rising edge of clk
//   raddr/rdata    combinational read port
module fifo_ram
    import conv_out_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = CONV_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [$clog2(DEPTH)-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [$clog2(DEPTH)-1:0]  raddr,
    output logic [DATA_WIDTH-1:0]     rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/conv_out_fifo.sv
// conv_out_fifo
// This is a first-word-fall-through FIFO placed between the conv core and its
// consumer. It raises a registered almost-full flag to stall the conv core
// early enough to absorb the words still in its pipeline.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   wr_data/wr_valid  conv output word and write request
//   fifo_almost_full  registered back-pressure to the conv stall input
//   rd_data/rd_valid  head-of-queue word (FWFT) and its valid flag
//   rd_ready          consumer accept; a pop happens on rd_valid && rd_ready
//   count             current occupancy, 0..DEPTH
//   overflow          sticky flag, set when a write is dropped while full
// DEPTH must be a power of two and at least 4.
module conv_out_fifo
    import conv_out_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = CONV_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH_DEFAULT,
    parameter int AF_MARGIN  = AF_MARGIN_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_valid,
    output logic                    fifo_almost_full,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);
    // The flag condition (DEPTH - count_next) <= AF_MARGIN is rewritten as a
    // threshold on count_next. It is clamped so that a margin >= DEPTH holds
    // the flag high instead of underflowing.
    localparam int AF_THRESH = (AF_MARGIN >= DEPTH) ? 0 : DEPTH - AF_MARGIN;

    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count_next;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  full, push, pop, drop;

    // Full and empty come from count, because the pointers are equal in both states.
    assign full     = (count == CW'(DEPTH));
    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    // When the FIFO is full, a write is still accepted if the head leaves in the same cycle.
    assign push     = wr_valid && (!full || pop);
    assign drop     = wr_valid && full && !pop;

    assign count_next = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            fifo_almost_full <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            // The pointer width is log2(DEPTH), so the increments wrap modulo DEPTH.
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count            <= count_next;
            fifo_almost_full <= (count_next >= CW'(AF_THRESH));
            if (drop) overflow <= 1'b1;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // Storage is not reset. The output is masked while empty so that
    // uninitialised RAM never shows up on rd_data.
    assign rd_data = rd_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_conv_out_fifo.sv
module tb_conv_out_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AFM   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          rd_ready = 1'b0;
    logic          fifo_almost_full, rd_valid, overflow;
    logic [DW-1:0] rd_data;
    logic [4:0]    count;

    int checks = 0;
    int errors = 0;

    // Reference model: mq is the FIFO contents after the last edge. sb holds
    // the words expected at the output, in the order they will appear.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] sb[$];
    bit            m_ovf = 1'b0;
    bit            m_af  = 1'b0;

    conv_out_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
        .clk              (clk),
        .rst              (rst),
        .wr_data          (wr_data),
        .wr_valid         (wr_valid),
        .fifo_almost_full (fifo_almost_full),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .count            (count),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // This task applies the current inputs for one clock edge and advances the model.
    task automatic step();
        bit p, w;
        p = (mq.size() != 0) && rd_ready;
        w = wr_valid && ((mq.size() < DEPTH) || p);
        if (w) sb.push_back(wr_data);
        @(posedge clk);
        if (p) void'(mq.pop_front());
        if (w) mq.push_back(wr_data);
        if (wr_valid && !w) m_ovf = 1'b1;
        m_af = (DEPTH - int'(mq.size())) <= AFM;
        #1;
    endtask

    task automatic model_clear();
        mq.delete();
        sb.delete();
        m_ovf = 1'b0;
        m_af  = 1'b0;
    endtask

    task automatic do_reset();
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic write_word(input logic [DW-1:0] d, input bit rr);
        wr_valid = 1'b1;
        wr_data  = d;
        rd_ready = rr;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic drain();
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && mq.size() != 0; i++) step();
        rd_ready = 1'b0;
        chk("drain_empty", 32'(count), 32'd0);
    endtask

    // The monitor compares the DUT against the model in mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("count", 32'(count), 32'(mq.size()));
            chk("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
            chk("almost_full", 32'(fifo_almost_full), 32'(m_af));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: rd_valid=1 with no expected word, rd_data=0x%0h", rd_data);
                end else begin
                    chk("rd_data", 32'(rd_data), 32'(sb[0]));
                    if (rd_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int next;
        int budget;
        #1;
        // The outputs are checked while reset is held.
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_af", 32'(fifo_almost_full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_rd_data_known", 32'($isunknown(rd_data)), 32'd0);
        do_reset();

        // Fill and almost-full: the flag rises after the 12th write edge.
        for (int i = 1; i <= 12; i++) begin
            write_word(DW'(i), 1'b0);
            if (i == 11) chk("fill_af_at11", 32'(fifo_almost_full), 32'd0);
        end
        chk("fill_af_at12", 32'(fifo_almost_full), 32'd1);
        chk("fill_count12", 32'(count), 32'd12);

        // Overflow: word 17 is dropped, and the flag stays set.
        for (int i = 13; i <= 17; i++) write_word(DW'(i), 1'b0);
        chk("ovf_count16", 32'(count), 32'd16);
        chk("ovf_flag", 32'(overflow), 32'd1);
        drain();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        do_reset();
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // FWFT latency.
        write_word(16'hABCD, 1'b0);
        chk("fwft_valid", 32'(rd_valid), 32'd1);
        chk("fwft_data", 32'(rd_data), 32'hABCD);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("fwft_popped", 32'(rd_valid), 32'd0);

        // Push and pop together while full.
        for (int i = 0; i < DEPTH; i++) write_word(DW'(16'h0100 + i), 1'b0);
        chk("full_count", 32'(count), 32'd16);
        write_word(16'h1234, 1'b1);
        chk("conc_count", 32'(count), 32'd16);
        chk("conc_overflow", 32'(overflow), 32'd0);
        chk("conc_head", 32'(rd_data), 32'h0101);
        drain();

        // Wrap-order test: the producer honours almost-full.
        next = 0;
        budget = 0;
        while (next < 40 && budget < 2000) begin
            wr_valid = !fifo_almost_full && ($urandom_range(0, 3) != 0);
            wr_data  = DW'(next);
            rd_ready = $urandom_range(0, 1);
            if (wr_valid) next++;
            step();
            budget++;
        end
        wr_valid = 1'b0;
        chk("wrap_all_written", 32'(next), 32'd40);
        drain();
        chk("wrap_no_overflow", 32'(overflow), 32'd0);

        // Random stress that ignores almost-full, so the FIFO hits full and drops words.
        for (int i = 0; i < 300; i++) begin
            wr_valid = ($urandom_range(0, 9) < 7);
            wr_data  = DW'($urandom);
            rd_ready = ($urandom_range(0, 9) < 3);
            step();
        end
        wr_valid = 1'b0;
        drain();
        do_reset();

        // Reset in mid-operation, pulsed between edges.
        for (int i = 0; i < 7; i++) write_word(DW'(16'h0A00 + i), 1'b0);
        chk("mid_count7", 32'(count), 32'd7);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_af", 32'(fifo_almost_full), 32'd0);
        #1 rst = 1'b0;
        model_clear();
        write_word(16'h00FF, 1'b0);
        chk("mid_first_data", 32'(rd_data), 32'h00FF);
        chk("mid_first_count", 32'(count), 32'd1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_out_fifo.md
CONV_OUT_FIFO -- requirements
Module: conv_out_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving the conv output word width (8*OUT_CHANNEL in relu mode).
REQ-002 SHALL have parameter DEPTH, default 16, giving the number of entries; it must be a power of two, minimum 4.
REQ-003 SHALL have parameter AF_MARGIN, default 4, giving the free-entry count at or below which the almost-full flag asserts; it covers conv pipeline slack.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port wr_data, input, DATA_WIDTH bits: conv o_data.
REQ-007 SHALL have port wr_valid, input, 1 bit: conv o_valid, a write request.
REQ-008 SHALL have port fifo_almost_full, output, 1 bit: back-pressure to the conv stall input.
REQ-009 SHALL have port rd_data, output, DATA_WIDTH bits: head-of-queue word, first-word-fall-through (FWFT).
REQ-010 SHALL have port rd_valid, output, 1 bit: rd_data is valid.
REQ-011 SHALL have port rd_ready, input, 1 bit: the downstream consumer accepts; a pop occurs when rd_valid && rd_ready.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag set when a write is dropped.

Function
REQ-014 SHALL accept a write on every cycle with wr_valid=1 when not full, or when full with a simultaneous pop.
REQ-015 SHALL drop a write when full with no simultaneous pop, leave storage and count unchanged, and set overflow at the next edge.
REQ-016 SHALL register fifo_almost_full, asserted when (DEPTH - count_next) <= AF_MARGIN and deasserted otherwise; it is updated on the same edge as count.
REQ-017 SHALL drive rd_valid=1 iff count != 0, with rd_data equal to the oldest stored word (FWFT).
REQ-018 SHALL have a write-to-read latency of 1 cycle: a word written to an empty FIFO at edge N is visible on rd_data/rd_valid after edge N.
REQ-019 SHALL ignore rd_ready when empty; there is no underflow, and count stays at 0.
REQ-020 SHALL, on a simultaneous push and pop at nonzero count, keep count unchanged and advance both pointers.
REQ-021 SHALL keep read and write pointers at $clog2(DEPTH) bits, wrapping modulo DEPTH; full/empty are derived from count, never from pointer equality alone.
REQ-022 SHALL preserve word order exactly (strict FIFO), with no data modification.
REQ-023 SHALL make storage contents don't-care after reset; rd_data while rd_valid=0 is unspecified but must not be X in a simulation that starts from reset.

Reset
REQ-024 SHALL, while rst=1, asynchronously force count=0, both pointers=0, rd_valid=0, fifo_almost_full=0, and overflow=0.
REQ-025 SHALL, on reset mid-operation, discard all buffered words, and SHALL act on the first write after rst deasserts normally.

Structure
REQ-026 SHALL define AF_MARGIN default and pointer-width helper constants in the shared conv package/header alongside the conv parameter constants.
REQ-027 SHALL place storage in one sub-module, fifo_ram (simple dual-port, synchronous write, asynchronous read, DATA_WIDTH x DEPTH); all control logic stays in conv_out_fifo.

Verification
REQ-028 SHALL include a fill test: DEPTH=16, AF_MARGIN=4, rd_ready=0, write 12 words 0x0001..0x000C -> fifo_almost_full rises after the 12th write edge, count=12.
REQ-029 SHALL include an overflow test: with rd_ready=0, write 17 words -> count=16, word 17 dropped, overflow=1 and stays 1 until rst.
REQ-030 SHALL include an FWFT latency test: write 0xABCD into an empty FIFO at edge N -> rd_valid=1 and rd_data=0xABCD after edge N; with rd_ready=1, pop at N+1 -> rd_valid=0.
REQ-031 SHALL include a full-concurrent test: at count=16, assert wr_valid and rd_ready together with 0x1234 -> head pops, 0x1234 is stored, count stays 16, overflow stays 0.
REQ-032 SHALL include a wrap-order test: 40 words 0..39 with random rd_ready and wr_valid -> the output sequence is exactly 0..39, no overflow while the producer honours fifo_almost_full.
REQ-033 SHALL include a reset-mid-operation test: at count=7, pulse rst asynchronously between edges -> count=0, rd_valid=0, fifo_almost_full=0 immediately; the next write 0x00FF is read back first.
